rtc_timekeeper: RTL and testbench
=================================

RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick (legal range >= 2).
REQ-002 The block SHALL have parameter ALARM_EN, default 1, meaning include the alarm logic when 1; when 0, alarm_hit is tied 0.
REQ-003 The block SHALL have the following ports, with reset rst, asynchronous, active-high, and clock clk:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  count enable; 0 freezes the prescaler and the time
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
- set_valid  in  1  time-load request
- set_ready  out  1  load accept qualifier
- set_hh  in  5  load hours, binary 0-23
- set_mm  in  6  load minutes, binary 0-59
- set_ss  in  6  load seconds, binary 0-59
- set_err  out  1  one-cycle pulse on a rejected load
- alarm_wr  in  1  write and arm the alarm
- alarm_clr  in  1  disarm the alarm
- alarm_hh  in  5  alarm hours, 0-23
- alarm_mm  in  6  alarm minutes, 0-59
- sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  out  4 each  BCD display digits
- pm  out  1  1 when the internal hour is >= 12 (valid in both modes)
- sec_tick  out  1  one-cycle pulse in the cycle the time advances
- alarm_hit  out  1  one-cycle alarm pulse

Function
REQ-004 The prescaler SHALL count 0..TICK_DIV-1 while en=1, and SHALL generate an internal tick when its count equals TICK_DIV-1 and en=1, wrapping to 0 on that edge.
REQ-005 The prescaler width SHALL be $clog2(TICK_DIV), and its value SHALL hold while en=0.
REQ-006 Time SHALL be held internally as 24-hour BCD digits; on a tick, seconds SHALL increment, 59 SHALL wrap to 00 with a carry to minutes, minutes SHALL wrap the same way with a carry to hours, and 23:59:59 SHALL become 00:00:00.
REQ-007 sec_tick SHALL be registered high for exactly the cycle in which the time registers hold the newly advanced value.
REQ-008 The display outputs SHALL be combinational from the time registers, with zero cycles of latency.
REQ-009 In 12-hour mode, the hour digits SHALL map internal hour 0 to 12, hours 1-12 unchanged, and hours 13-23 to h-12; minute and second digits SHALL be unaffected by mode.
REQ-010 Toggling mode_12h SHALL change only the displayed hour digits and SHALL NOT modify any internal state.
REQ-011 A load SHALL be accepted on a clk edge where set_valid and set_ready are both 1 and set_hh<=23, set_mm<=59 and set_ss<=59.
REQ-012 An accepted load SHALL take effect on that edge, SHALL clear the prescaler to 0, and SHALL drive set_ready to 0 for the following cycle only.
REQ-013 A load request with any field out of range SHALL change no state, SHALL pulse set_err for one cycle, and SHALL leave set_ready at 1.
REQ-014 When an accepted load and a tick occur on the same edge, the load SHALL win: the tick is discarded and no sec_tick is generated.
REQ-015 Loads SHALL be accepted regardless of en.
REQ-016 alarm_wr with in-range alarm_hh and alarm_mm SHALL store the alarm time and set the armed flag; an out-of-range alarm_wr SHALL be ignored.
REQ-017 alarm_clr SHALL clear the armed flag, and SHALL win over a simultaneous alarm_wr.
REQ-018 alarm_hit SHALL pulse in the sec_tick cycle whose new time equals alarm_hh:alarm_mm:00 while armed, and SHALL repeat daily until the alarm is disarmed.
REQ-019 A time load that lands exactly on the alarm time SHALL NOT assert alarm_hit.

Reset
REQ-020 When rst is asserted, the time SHALL be 00:00:00 and the prescaler SHALL be 0.
REQ-021 When rst is asserted, sec_tick, alarm_hit and set_err SHALL be 0.
REQ-022 When rst is asserted, the alarm SHALL be 00:00 and disarmed.
REQ-023 When rst is asserted, set_ready SHALL be 1, pm SHALL be 0, and the displayed hour SHALL be 00 in 24-hour mode or 12 in 12-hour mode.
REQ-024 A reset asserted mid-operation, including during the set_ready=0 cycle, SHALL abort all activity immediately.

Structure
REQ-025 Package rtc_pkg SHALL hold the constants MAX_HR=23, MAX_MIN=59, MAX_SEC=59 and BCD_W=4.
REQ-026 Sub-module bcd_digit_ctr SHALL implement one BCD digit with parameterised modulus, increment-enable, synchronous load and carry-out, and SHALL be instantiated per time digit.

Verification
REQ-027 With TICK_DIV=4, rst is released and en is held at 1 -> sec_tick SHALL pulse every 4 cycles and sec_ones SHALL count 0..9, then sec_tens increments.
REQ-028 Load 23:59:58, then two ticks -> the display SHALL read 23:59:59 then 00:00:00, with pm going from 1 to 0.
REQ-029 mode_12h=1 with loads of 00:00:00, 12:00:00 and 13:05:00 -> the hour display SHALL read 12, 12 and 01, with pm reading 0, 1 and 1 respectively.
REQ-030 set_valid asserted on the cycle the prescaler equals 3 -> the load SHALL win, with no sec_tick that cycle and set_ready=0 for one cycle; a load of 24:00:00 SHALL pulse set_err and change no state.
REQ-031 Alarm 07:30 written, time loaded to 07:29:59, then one tick -> alarm_hit SHALL pulse once; after alarm_clr, the same sequence SHALL produce no alarm_hit.
REQ-032 rst asserted while en=1 at 12:34:56 -> all outputs SHALL be at their reset values asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants and BCD helpers for the real-time-clock timekeeper.
package rtc_pkg;

   localparam int MAX_HR  = 23;
   localparam int MAX_MIN = 59;
   localparam int MAX_SEC = 59;
   localparam int BCD_W   = 4;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
   } bcd2_t;

   // Binary 0..69 to two BCD digits by repeated subtraction.
   function automatic bcd2_t to_bcd(input logic [6:0] v);
      bcd2_t      r;
      logic [6:0] rem;
      r.tens = '0;
      rem    = v;
      for (int i = 0; i < 6; i++) begin
         if (rem >= 7'd10) begin
            rem    = rem - 7'd10;
            r.tens = r.tens + 4'd1;
         end
      end
      r.ones = 4'(rem);
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit counting 0..MODULUS-1 with increment-enable, synchronous load and carry-out.
module bcd_digit_ctr
   import rtc_pkg::*;
#(
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   localparam logic [BCD_W-1:0] LAST = BCD_W'(MODULUS - 1);

   assign carry = inc && (q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (inc) begin
         q <= (q == LAST) ? '0 : q + BCD_W'(1);
      end
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day clock: prescaled one-second tick, BCD HH:MM:SS, time load with range check,
// 12/24-hour display and a daily HH:MM alarm.
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int TICK_DIV = 100000000,
   parameter int ALARM_EN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       mode_12h,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [4:0] set_hh,
   input  logic [5:0] set_mm,
   input  logic [5:0] set_ss,
   output logic       set_err,
   input  logic       alarm_wr,
   input  logic       alarm_clr,
   input  logic [4:0] alarm_hh,
   input  logic [5:0] alarm_mm,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] hr_tens,
   output logic       pm,
   output logic       sec_tick,
   output logic       alarm_hit
);

   localparam int            PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]    presc;
   logic [BCD_W-1:0] s1, s10, m1, m10, h1, h10;
   logic             c_s1, c_s10, c_m1, c_m10, c_h1, c_h10;
   logic             in_range, accept, tick, adv, day_wrap, hr_load;
   bcd2_t            ld_h, ld_m, ld_s, al_h, al_m, hr_dig;
   logic             armed, al_ok;
   logic [4:0]       hr_bin, hr_disp;

   assign in_range = (set_hh <= 5'(MAX_HR)) && (set_mm <= 6'(MAX_MIN)) && (set_ss <= 6'(MAX_SEC));
   assign accept   = set_valid && set_ready && in_range;
   assign tick     = en && (presc == PRE_LAST);
   assign adv      = tick && !accept;

   assign ld_h = to_bcd({2'b00, set_hh});
   assign ld_m = to_bcd({1'b0, set_mm});
   assign ld_s = to_bcd({1'b0, set_ss});

   // c_h10 can only fire from an out-of-range hour; folding it in forces a return to 00.
   assign day_wrap = c_m10 && (((h10 == 4'd2) && (h1 == 4'd3)) || c_h10);
   assign hr_load  = accept || day_wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (accept) begin
         presc <= '0;
      end else if (en) begin
         presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
      end
   end

   bcd_digit_ctr #(.MODULUS(10)) u_s1 (.clk(clk), .rst(rst), .inc(adv), .load(accept),
      .load_val(ld_s.ones), .q(s1), .carry(c_s1));
   bcd_digit_ctr #(.MODULUS(6)) u_s10 (.clk(clk), .rst(rst), .inc(c_s1), .load(accept),
      .load_val(ld_s.tens), .q(s10), .carry(c_s10));
   bcd_digit_ctr #(.MODULUS(10)) u_m1 (.clk(clk), .rst(rst), .inc(c_s10), .load(accept),
      .load_val(ld_m.ones), .q(m1), .carry(c_m1));
   bcd_digit_ctr #(.MODULUS(6)) u_m10 (.clk(clk), .rst(rst), .inc(c_m1), .load(accept),
      .load_val(ld_m.tens), .q(m10), .carry(c_m10));
   bcd_digit_ctr #(.MODULUS(10)) u_h1 (.clk(clk), .rst(rst), .inc(c_m10), .load(hr_load),
      .load_val(accept ? ld_h.ones : 4'd0), .q(h1), .carry(c_h1));
   bcd_digit_ctr #(.MODULUS(3)) u_h10 (.clk(clk), .rst(rst), .inc(c_h1), .load(hr_load),
      .load_val(accept ? ld_h.tens : 4'd0), .q(h10), .carry(c_h10));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_tick  <= 1'b0;
         set_ready <= 1'b1;
         set_err   <= 1'b0;
      end else begin
         sec_tick  <= adv;
         set_ready <= !accept;
         set_err   <= set_valid && set_ready && !in_range;
      end
   end

   assign al_ok = (alarm_hh <= 5'(MAX_HR)) && (alarm_mm <= 6'(MAX_MIN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         al_h  <= '0;
         al_m  <= '0;
         armed <= 1'b0;
      end else if (alarm_clr) begin
         armed <= 1'b0;
      end else if (alarm_wr && al_ok) begin
         al_h  <= to_bcd({2'b00, alarm_hh});
         al_m  <= to_bcd({1'b0, alarm_mm});
         armed <= 1'b1;
      end
   end

   // sec_tick only follows a real advance, so a load onto the alarm time never hits.
   assign alarm_hit = (ALARM_EN != 0) && sec_tick && armed && ({h10, h1} == al_h) &&
                      ({m10, m1} == al_m) && (s10 == 4'd0) && (s1 == 4'd0);

   assign hr_bin = 5'(h10) * 5'd10 + 5'(h1);
   assign pm     = (hr_bin >= 5'd12);

   always_comb begin
      hr_disp = hr_bin;
      if (mode_12h) begin
         if (hr_bin == 5'd0) begin
            hr_disp = 5'd12;
         end else if (hr_bin > 5'd12) begin
            hr_disp = hr_bin - 5'd12;
         end
      end
   end

   assign hr_dig   = to_bcd({2'b00, hr_disp});
   assign hr_tens  = hr_dig.tens;
   assign hr_ones  = hr_dig.ones;
   assign min_tens = m10;
   assign min_ones = m1;
   assign sec_tens = s10;
   assign sec_ones = s1;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper at TICK_DIV=4: cycle model with tick scoreboard, display table, corner sequences.
module tb_rtc_timekeeper;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, mode_12h, set_valid, alarm_wr, alarm_clr;
   logic [4:0] set_hh, alarm_hh;
   logic [5:0] set_mm, set_ss, alarm_mm;
   logic       set_ready, set_err, pm, sec_tick, alarm_hit;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;

   rtc_timekeeper #(.TICK_DIV(4), .ALARM_EN(1)) dut (
      .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h),
      .set_valid(set_valid), .set_ready(set_ready),
      .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err),
      .alarm_wr(alarm_wr), .alarm_clr(alarm_clr), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
      .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
      .hr_ones(hr_ones), .hr_tens(hr_tens), .pm(pm), .sec_tick(sec_tick), .alarm_hit(alarm_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] t;
      bit          hit;
   } exp_t;

   typedef struct {
      bit         mode;
      int         hh, mm, ss;
      logic [7:0] ehr;
      bit         epm;
   } vec_t;

   exp_t sb[$];
   vec_t vt[9];
   int   n_asrt, n_fail, n_hits;
   int   m_time, m_presc, m_alarm;
   bit   m_ready, m_armed;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_asrt++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] dig(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] disp();
      return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic model_reset();
      m_time  = 0;
      m_presc = 0;
      m_alarm = 0;
      m_ready = 1'b1;
      m_armed = 1'b0;
      sb.delete();
   endtask

   // One clock: advance the model, push expected tick results, then check after the edge.
   task automatic step();
      bit   rng, acc, err, tk, adv, hit;
      exp_t e;
      rng = (set_hh <= 23) && (set_mm <= 59) && (set_ss <= 59);
      acc = set_valid && m_ready && rng;
      err = set_valid && m_ready && !rng;
      tk  = en && (m_presc == 3);
      adv = tk && !acc;
      if (acc) begin
         m_time  = set_hh * 3600 + set_mm * 60 + set_ss;
         m_presc = 0;
      end else if (en) begin
         m_presc = (m_presc + 1) % 4;
         if (tk) m_time = (m_time + 1) % 86400;
      end
      if (alarm_clr) m_armed = 1'b0;
      else if (alarm_wr && alarm_hh <= 23 && alarm_mm <= 59) begin
         m_alarm = alarm_hh * 60 + alarm_mm;
         m_armed = 1'b1;
      end
      m_ready = !acc;
      if (adv) begin
         e.t   = dig(m_time);
         e.hit = m_armed && (m_time == m_alarm * 60);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("set_ready", set_ready, m_ready);
      chk("set_err", set_err, err);
      chk("sec_tick", sec_tick, adv);
      hit = 1'b0;
      if (adv) begin
         e   = sb.pop_front();
         hit = e.hit;
         if (sec_tick) chk("tick_time", disp(), e.t);
      end
      chk("alarm_hit", alarm_hit, hit);
      if (alarm_hit) n_hits++;
   endtask

   task automatic load(input int h, input int m, input int s);
      set_valid = 1'b1;
      set_hh    = 5'(h);
      set_mm    = 6'(m);
      set_ss    = 6'(s);
      step();
      set_valid = 1'b0;
      step();
   endtask

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         step();
         seen = sec_tick;
      end
      chk("tick_timeout", seen, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] ed;
      n_asrt = 0; n_fail = 0; n_hits = 0;
      en = 0; mode_12h = 0; set_valid = 0; alarm_wr = 0; alarm_clr = 0;
      set_hh = 0; set_mm = 0; set_ss = 0; alarm_hh = 0; alarm_mm = 0;
      rst = 1'b0;

      vt[0] = '{1'b1,  0,  0,  0, 8'h12, 1'b0};
      vt[1] = '{1'b1, 12,  0,  0, 8'h12, 1'b1};
      vt[2] = '{1'b1, 13,  5,  0, 8'h01, 1'b1};
      vt[3] = '{1'b0,  0,  0,  0, 8'h00, 1'b0};
      vt[4] = '{1'b0, 23, 59, 58, 8'h23, 1'b1};
      vt[5] = '{1'b1, 23, 59, 58, 8'h11, 1'b1};
      vt[6] = '{1'b1, 11, 45, 30, 8'h11, 1'b0};
      vt[7] = '{1'b1,  1,  0,  0, 8'h01, 1'b0};
      vt[8] = '{1'b1, 20,  0,  7, 8'h08, 1'b1};

      // Reset state, before any clock edge.
      #1 rst = 1'b1;
      #2;
      chk("rst_time", disp(), 24'h000000);
      chk("rst_pm", pm, 0);
      chk("rst_ready", set_ready, 1);
      chk("rst_tick", sec_tick, 0);
      chk("rst_err", set_err, 0);
      chk("rst_alarm", alarm_hit, 0);
      mode_12h = 1'b1;
      #1;
      chk("rst_hr12", {hr_tens, hr_ones}, 8'h12);
      mode_12h = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      // Free run: tick every 4 cycles, seconds 0..9 then tens.
      en = 1'b1;
      repeat (42) step();
      chk("count_10s", disp(), 24'h000010);
      en = 1'b0;
      repeat (6) step();
      chk("frozen", disp(), 24'h000010);
      en = 1'b1;
      wait_tick();
      chk("resume", disp(), 24'h000011);

      // Midnight rollover.
      load(23, 59, 58);
      chk("load_235958", disp(), 24'h235958);
      wait_tick();
      chk("t235959", disp(), 24'h235959);
      chk("pm_before_wrap", pm, 1);
      wait_tick();
      chk("t000000", disp(), 24'h000000);
      chk("pm_after_wrap", pm, 0);

      // Load colliding with a tick, held request while not ready, then an out-of-range load.
      for (int i = 0; i < 8 && m_presc != 3; i++) step();
      set_valid = 1'b1; set_hh = 10; set_mm = 20; set_ss = 30;
      step();
      chk("coll_no_tick", sec_tick, 0);
      chk("coll_ready", set_ready, 0);
      chk("coll_time", disp(), 24'h102030);
      set_hh = 5; set_mm = 5; set_ss = 5;
      step();
      chk("coll_hold_time", disp(), 24'h102030);
      set_hh = 24; set_mm = 0; set_ss = 0;
      step();
      set_valid = 1'b0;
      chk("err_pulse", set_err, 1);
      chk("err_time", disp(), 24'h102030);
      step();
      chk("err_clear", set_err, 0);

      // Display table, en frozen.
      en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         mode_12h = 1'b0;
         load(vt[i].hh, vt[i].mm, vt[i].ss);
         mode_12h = vt[i].mode;
         #1;
         ed = dig(vt[i].hh * 3600 + vt[i].mm * 60 + vt[i].ss);
         chk("tbl_hour", {hr_tens, hr_ones}, vt[i].ehr);
         chk("tbl_pm", pm, vt[i].epm);
         chk("tbl_minsec", {min_tens, min_ones, sec_tens, sec_ones}, ed[15:0]);
         mode_12h = !vt[i].mode;
         #1;
         mode_12h = 1'b0;
         #1;
         chk("tbl_24h", disp(), ed);
      end

      // Alarm: hit, load onto alarm time, clear-vs-write, invalid write keeps old alarm.
      alarm_wr = 1'b1; alarm_hh = 7; alarm_mm = 30;
      step();
      alarm_wr = 1'b0;
      load(7, 29, 59);
      en = 1'b1;
      wait_tick();
      chk("alarm_once", n_hits, 1);
      chk("alarm_time", disp(), 24'h073000);
      load(7, 30, 0);
      chk("load_on_alarm", n_hits, 1);
      en = 1'b0;
      alarm_clr = 1'b1; alarm_wr = 1'b1;
      step();
      alarm_clr = 1'b0; alarm_wr = 1'b0;
      load(7, 29, 59);
      en = 1'b1;
      wait_tick();
      chk("after_clr", n_hits, 1);
      en = 1'b0;
      alarm_wr = 1'b1;
      step();
      alarm_hh = 24;
      step();
      alarm_wr = 1'b0; alarm_hh = 7;
      load(7, 29, 59);
      en = 1'b1;
      wait_tick();
      chk("bad_write_ignored", n_hits, 2);

      // Asynchronous reset during the not-ready cycle at 12:34:56.
      set_valid = 1'b1; set_hh = 12; set_mm = 34; set_ss = 56;
      step();
      set_valid = 1'b0;
      chk("pre_rst", disp(), 24'h123456);
      #2 rst = 1'b1;
      #1;
      chk("arst_time", disp(), 24'h000000);
      chk("arst_pm", pm, 0);
      chk("arst_ready", set_ready, 1);
      chk("arst_tick", sec_tick, 0);
      chk("arst_err", set_err, 0);
      chk("arst_alarm", alarm_hit, 0);
      mode_12h = 1'b1;
      #1;
      chk("arst_hr12", {hr_tens, hr_ones}, 8'h12);
      mode_12h = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      wait_tick();
      chk("post_rst_tick", disp(), 24'h000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
